// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and register-index constants for the write-back port arbiter.
package wb_port_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  function automatic logic is_x0(input logic [REG_AW-1:0] r);
    return r == REG_X0;
  endfunction
endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO for long-latency results; entries are packed {rd, data}.
module wb_result_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port owner: pipeline WB has priority, long-latency results
// queue in a FIFO, a per-register scoreboard tracks pending results.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wen,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_data,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              lu_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd_chk,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              stall_req,
  output logic [CW-1:0]     fifo_count
);
  localparam int EW = REG_AW + XLEN;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [EW-1:0]     head;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_data;
  logic              full, empty, push, pop, pipe_req;
  logic [31:0]       sb_q, sb_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;

  assign head_rd   = head[EW-1:XLEN];
  assign head_data = head[XLEN-1:0];

  wb_result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({lu_rd, lu_data}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    pipe_req = pipe_wen && !is_x0(pipe_rd);
    pop      = !pipe_req && !empty;
    push     = lu_valid && !full;
    // An rd=0 head still pops, it just never reaches the register file.
    rf_wen   = rst_n && (pipe_req || (pop && !is_x0(head_rd)));
    rf_waddr = pipe_req ? pipe_rd   : head_rd;
    rf_wdata = pipe_req ? pipe_data : head_data;

    // Clear before set so a same-cycle reissue of the popping register stays pending.
    sb_d = sb_q;
    if (pop)         sb_d[head_rd]  = 1'b0;
    if (issue_valid) sb_d[issue_rd] = 1'b1;
    sb_d[REG_X0] = 1'b0;

    starve_d = starve_q;
    if (empty || pop)                         starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))   starve_d = starve_q + 1'b1;

    stall_d = (starve_q == SW'(STARVE_LIMIT)) || (fifo_count == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q     <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      sb_q     <= sb_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign lu_ready  = !full;
  assign rs1_busy  = sb_q[rs1];
  assign rs2_busy  = sb_q[rs2];
  assign rd_busy   = sb_q[rd_chk];
  assign stall_req = stall_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed plus random stimulus against a queue-based reference of the write-back port.
module tb_wb_port_arbiter;
  localparam int XLEN = 32, DEPTH = 2, LIM = 4, CW = $clog2(DEPTH) + 1;

  logic clk = 0, rst_n = 0;
  logic pipe_wen = 0, lu_valid = 0, issue_valid = 0;
  logic [4:0] pipe_rd = 0, lu_rd = 0, issue_rd = 0, rs1 = 0, rs2 = 0, rd_chk = 0;
  logic [XLEN-1:0] pipe_data = 0, lu_data = 0;
  logic lu_ready, rs1_busy, rs2_busy, rd_busy, rf_wen, stall_req;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [CW-1:0] fifo_count;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2), .rd_chk(rd_chk),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall_req(stall_req), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t q[$];
  logic [31:0] sb;
  int starve;
  logic stall;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete(); sb = 0; starve = 0; stall = 0;
  endtask

  // Expected port behaviour straight from the arbitration rules.
  task automatic settle();
    bit preq, pop, ew;
    #2;
    preq = pipe_wen && pipe_rd != 0;
    pop  = !preq && q.size() > 0;
    ew   = preq;
    if (pop) ew = q[0].rd != 0;
    chk("rf_wen", rf_wen, ew);
    if (ew) begin
      chk("rf_waddr", rf_waddr, preq ? pipe_rd : q[0].rd);
      chk("rf_wdata", rf_wdata, preq ? pipe_data : q[0].data);
    end
    chk("lu_ready", lu_ready, q.size() < DEPTH);
    chk("fifo_count", fifo_count, q.size());
    chk("rs1_busy", rs1_busy, sb[rs1]);
    chk("rs2_busy", rs2_busy, sb[rs2]);
    chk("rd_busy", rd_busy, sb[rd_chk]);
    chk("stall_req", stall_req, stall);
  endtask

  task automatic tick();
    bit preq, pop, push, nstall;
    int nstarve;
    @(posedge clk);
    preq    = pipe_wen && pipe_rd != 0;
    pop     = !preq && q.size() > 0;
    push    = lu_valid && q.size() < DEPTH;
    nstall  = (starve == LIM) || (q.size() == DEPTH);
    nstarve = (q.size() == 0 || pop) ? 0 : (starve < LIM ? starve + 1 : starve);
    if (pop) begin
      if (q[0].rd != 0) sb[q[0].rd] = 1'b0;
      void'(q.pop_front());
    end
    if (push) q.push_back('{rd: lu_rd, data: lu_data});
    if (issue_valid && issue_rd != 0) sb[issue_rd] = 1'b1;
    starve = nstarve;
    stall  = nstall;
    #1;
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird);
    pipe_wen = pw; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    issue_valid = iv; issue_rd = ird;
  endtask

  task automatic lk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    rs1 = a; rs2 = b; rd_chk = c;
  endtask

  task automatic step();
    settle(); tick();
  endtask

  logic [4:0] r;

  initial begin
    model_reset();
    // Power-on reset
    #3;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_stall", stall_req, 0);
    #9 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_lu_ready", lu_ready, 1);

    // Idle pipe: issue rd5, result arrives, written the cycle after push
    lk(5, 0, 5);
    drive(0, 0, 0, 0, 0, 0, 1, 5); step();
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0); settle();
    chk("no_bypass", rf_wen, 0);
    chk("busy5_pend", rs1_busy, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("idle_wen", rf_wen, 1);
    chk("idle_waddr", rf_waddr, 5);
    chk("idle_wdata", rf_wdata, 32'hDEADBEEF);
    chk("busy5_wcyc", rs1_busy, 1);
    tick();
    settle();
    chk("busy5_clear", rs1_busy, 0);
    tick();

    // Collision: pipeline wins, head waits
    drive(0, 0, 0, 1, 9, 32'h99, 0, 0); step();
    drive(1, 3, 32'h11, 0, 0, 0, 0, 0); settle();
    chk("coll_waddr", rf_waddr, 3);
    chk("coll_wdata", rf_wdata, 32'h11);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("coll_head", rf_waddr, 9);
    tick();

    // Full FIFO while pipeline holds the port
    drive(1, 2, 32'h22, 1, 10, 32'hA, 0, 0); step();
    drive(1, 2, 32'h22, 1, 11, 32'hB, 0, 0); step();
    drive(1, 2, 32'h22, 0, 0, 0, 0, 0); settle();
    chk("full_ready", lu_ready, 0);
    tick();
    settle();
    chk("full_stall", stall_req, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("drain_head", rf_waddr, 10);
    tick();
    settle();
    chk("drain_ready", lu_ready, 1);
    tick();
    repeat (3) step();
    chk("drain_stall", stall_req, 0);

    // Starvation of a single entry
    drive(1, 4, 32'h44, 1, 12, 32'hC, 0, 0); step();
    drive(1, 4, 32'h44, 0, 0, 0, 0, 0);
    repeat (6) step();
    chk("starve_stall", stall_req, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("starve_pop", rf_waddr, 12);
    tick();
    repeat (2) step();
    chk("starve_clear", stall_req, 0);

    // x0 handling and same-cycle set/clear
    drive(0, 0, 0, 1, 13, 32'hD, 0, 0); step();
    drive(1, 0, 32'hEE, 0, 0, 0, 0, 0); settle();
    chk("x0_pipe_head", rf_waddr, 13);
    chk("x0_pipe_wen", rf_wen, 1);
    tick();
    lk(0, 6, 6);
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    settle();
    chk("x0_issue", rs1_busy, 0);
    tick();
    drive(0, 0, 0, 1, 0, 32'hF0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("x0_entry_wen", rf_wen, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 6); step();
    drive(0, 0, 0, 1, 6, 32'h66, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 6); settle();
    chk("setclr_wen", rf_waddr, 6);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
    chk("set_wins", rs1_busy | rs2_busy, 1);
    tick();
    drive(0, 0, 0, 1, 6, 32'h67, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();

    // Reset mid-operation
    lk(5, 7, 5);
    drive(0, 0, 0, 0, 0, 0, 1, 5); step();
    drive(0, 0, 0, 0, 0, 0, 1, 7); step();
    drive(1, 3, 32'h33, 1, 20, 32'h20, 0, 0); step();
    drive(1, 3, 32'h33, 1, 21, 32'h21, 0, 0); step();
    drive(1, 3, 32'h33, 0, 0, 0, 0, 0); settle();
    chk("pre_rst_count", fifo_count, 2);
    rst_n = 0; #1;
    chk("mid_rst_wen", rf_wen, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", {rs1_busy, rs2_busy, rd_busy}, 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3 rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", lu_ready, 1);

    // Random traffic obeying the producer/issue protocol
    for (int i = 0; i < 400; i++) begin
      pipe_wen  = ($urandom % 2) == 0;
      pipe_rd   = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_data = $urandom;
      lu_valid  = (q.size() < DEPTH) && ($urandom % 2 == 0);
      lu_rd     = 5'($urandom_range(0, 31));
      lu_data   = $urandom;
      r         = 5'($urandom_range(0, 31));
      issue_valid = !sb[r] && ($urandom % 3 == 0);
      issue_rd  = r;
      lk(5'($urandom), 5'($urandom), r);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
